// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic SDATA_IDLE = 1'b0;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable bit counter for piso_tx; tc_o flags the last bit position (WIDTH-1).
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready intake and a frame strobe.
// Optional trailing even-parity bit when PISO_TX_PARITY_EN is defined.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             cnt_load, cnt_en, cnt_tc;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign din_ready = (state_q == IDLE) && !reset;
    assign accept    = din_valid && din_ready;

    piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    // The first bit is driven on the accepting edge, so each SHIFT cycle
    // prepares the bit that appears after the next edge.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        sdata_d  = SDATA_IDLE;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SHIFT;
                    sdata_d  = head_bit(din);
                    sframe_d = 1'b1;
                    shreg_d  = shift_out(din);
                    cnt_load = 1'b1;
`ifdef PISO_TX_PARITY_EN
                    par_d    = ^din;
`endif
                end
            end
            SHIFT: begin
                if (!cnt_tc) begin
                    sdata_d  = head_bit(shreg_q);
                    sframe_d = 1'b1;
                    shreg_d  = shift_out(shreg_q);
                    cnt_en   = 1'b1;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    state_d  = PARITY;
                    sdata_d  = par_q;
                    sframe_d = 1'b1;
`else
                    state_d  = IDLE;
                    done_d   = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            sdata_q  <= SDATA_IDLE;
            sframe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PISO_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign sdata  = sdata_q;
    assign sframe = sframe_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances, frame timing,
// back-to-back, mid-frame reset, ignored valid while busy, optional parity.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic       vld_a, vld_b;
    logic       rdy_a, sd_a, sf_a, bz_a, dn_a;
    logic       rdy_b, sd_b, sf_b, bz_b, dn_b;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
        .sdata(sd_a), .sframe(sf_a), .busy(bz_a), .done(dn_a)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
        .sdata(sd_b), .sframe(sf_b), .busy(bz_b), .done(dn_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first frame cycle; returns in the done cycle without stepping.
    // inj > 0 pulses din_valid with 8'h55 on dut_a during that frame cycle.
    task automatic frame(input bit b, input logic [7:0] w, input logic par,
                         input int inj, input string tag);
        logic e;
        for (int i = 0; i < 8; i++) begin
            e = b ? w[i] : w[7-i];
            chk($sformatf("%s_sdata%0d", tag, i), b ? sd_b : sd_a, e);
            chk($sformatf("%s_sframe%0d", tag, i), b ? sf_b : sf_a, 1'b1);
            if (i == 0) begin
                chk({tag, "_busy"}, b ? bz_b : bz_a, 1'b1);
                chk({tag, "_rdy_busy"}, b ? rdy_b : rdy_a, 1'b0);
            end
            if (i == 7) chk({tag, "_nodone"}, b ? dn_b : dn_a, 1'b0);
            if (i + 1 == inj) begin
                vld_a = 1'b1;
                din_a = 8'h55;
            end
            step();
            if (i + 1 == inj) vld_a = 1'b0;
        end
`ifdef PISO_TX_PARITY_EN
        chk({tag, "_parity"}, b ? sd_b : sd_a, par);
        chk({tag, "_par_sframe"}, b ? sf_b : sf_a, 1'b1);
        chk({tag, "_par_nodone"}, b ? dn_b : dn_a, 1'b0);
        step();
`else
        if (par === 1'bx) chk({tag, "_par_arg"}, par, 1'b0);
`endif
        chk({tag, "_done"}, b ? dn_b : dn_a, 1'b1);
        chk({tag, "_done_sframe"}, b ? sf_b : sf_a, 1'b0);
        chk({tag, "_done_sdata"}, b ? sd_b : sd_a, 1'b0);
        chk({tag, "_done_busy"}, b ? bz_b : bz_a, 1'b0);
        chk({tag, "_done_rdy"}, b ? rdy_b : rdy_a, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        din_a = 8'h00;
        din_b = 8'h00;
        vld_a = 1'b0;
        vld_b = 1'b0;
        step();
        step();
        chk("rst_sdata", sd_a, 1'b0);
        chk("rst_sframe", sf_a, 1'b0);
        chk("rst_busy", bz_a, 1'b0);
        chk("rst_done", dn_a, 1'b0);
        chk("rst_rdy", rdy_a, 1'b0);
        reset = 1'b0;
        #1;
        chk("idle_rdy", rdy_a, 1'b1);

        // 1: 8'hA5 MSB first -> 1,0,1,0,0,1,0,1
        din_a = 8'hA5;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        frame(1'b0, 8'hA5, 1'b0, 0, "t1");
        step();
        chk("t1_done_pulse", dn_a, 1'b0);
        chk("t1_idle_sframe", sf_a, 1'b0);

        // 2: 8'h01 LSB first -> 1,0,0,0,0,0,0,0
        din_b = 8'h01;
        vld_b = 1'b1;
        step();
        vld_b = 1'b0;
        frame(1'b1, 8'h01, 1'b1, 0, "t2");
        step();

        // 3: back-to-back 8'hFF then 8'h00 with valid held high
        din_a = 8'hFF;
        vld_a = 1'b1;
        step();
        din_a = 8'h00;
        frame(1'b0, 8'hFF, 1'b0, 0, "t3a");
        step();
        vld_a = 1'b0;
        frame(1'b0, 8'h00, 1'b0, 0, "t3b");
        step();

        // 4: reset after three bits of 8'hA5, then 8'h3C
        din_a = 8'hA5;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        chk("t4_b0", sd_a, 1'b1);
        step();
        chk("t4_b1", sd_a, 1'b0);
        step();
        chk("t4_b2", sd_a, 1'b1);
        chk("t4_sf2", sf_a, 1'b1);
        reset = 1'b1;
        step();
        chk("t4_rst_sdata", sd_a, 1'b0);
        chk("t4_rst_sframe", sf_a, 1'b0);
        chk("t4_rst_busy", bz_a, 1'b0);
        chk("t4_rst_done", dn_a, 1'b0);
        reset = 1'b0;
        step();
        chk("t4_nodone", dn_a, 1'b0);
        chk("t4_rdy", rdy_a, 1'b1);
        din_a = 8'h3C;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        frame(1'b0, 8'h3C, 1'b0, 0, "t4");
        step();

        // 5: 8'h55 pulsed in frame cycle 3 of 8'hA5 is ignored
        din_a = 8'hA5;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        frame(1'b0, 8'hA5, 1'b0, 3, "t5");
        step();
        chk("t5_no_new_frame", sf_a, 1'b0);
        chk("t5_idle_busy", bz_a, 1'b0);

        // 6: 8'h07 -> parity 1 when the parity bit is compiled in
        din_a = 8'h07;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        frame(1'b0, 8'h07, 1'b1, 0, "t6");
        step();
        chk("t6_idle_sframe", sf_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
